prog_loader: RTL and testbench

- Synthesizable program/data loader between a word-stream source (testbench file reader, later a debug UART/JTAG bridge) and the core's instruction and data memory write ports.
- Accepts a valid/ready word stream tagged per word with a target memory (instruction or data) and writes each word at an auto-incremented address in that memory.
- Detects an end-of-program marker word, waits a programmable settle delay, then asserts a held start level to the core.
- Generalises the fixed instruction-only, free-running load-then-start flow: parametrised widths and depths, two memory channels, backpressure, overflow detection and reload.

---
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: loads a tagged valid/ready word stream into instruction/data
// memories at auto-incremented addresses, then starts the core after the
// end-of-program marker and a programmable settle delay.
module prog_loader #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     IMEM_DEPTH  = 1024,
  parameter int unsigned     DMEM_DEPTH  = 1024,
  parameter logic [XLEN-1:0] END_MARKER  = XLEN'(32'hDEADBEAF),
  parameter int unsigned     START_DELAY = 2
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iLoadReq,
  input  logic                          iReload,
  input  logic [XLEN-1:0]               iWord,
  input  logic                          iTarget,
  input  logic                          iValid,
  output logic                          oReady,
  output logic [$clog2(IMEM_DEPTH)-1:0] oInstAddr,
  output logic [XLEN-1:0]               oInst2Write,
  output logic                          oInstWen,
  output logic [$clog2(DMEM_DEPTH)-1:0] oDataAddr,
  output logic [XLEN-1:0]               oData2Write,
  output logic                          oDataWen,
  output logic                          oStart,
  output logic                          oBusy,
  output logic                          oOverflow,
  output logic [$clog2(IMEM_DEPTH):0]   oInstCount,
  output logic [$clog2(DMEM_DEPTH):0]   oDataCount
);

  localparam int unsigned IAW   = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW   = $clog2(DMEM_DEPTH);
  localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DELAY = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [DLY_W-1:0]   dly_cnt;
  logic               wr_inst, wr_data, ovf_hit, session_start;
  logic               is_marker;

  assign is_marker = (iWord == END_MARKER);

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state and per-cycle write/overflow decisions
  always_comb begin
    state_next    = state;
    wr_inst       = 1'b0;
    wr_data       = 1'b0;
    ovf_hit       = 1'b0;
    session_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (iLoadReq) begin
          state_next    = S_LOAD;
          session_start = 1'b1;
        end
      end
      S_LOAD: begin
        if (iValid && oReady) begin
          if (is_marker) begin
            state_next = S_DELAY;
          end else if (!iTarget) begin
            if (oInstCount < (IAW+1)'(IMEM_DEPTH)) wr_inst = 1'b1;
            else begin
              ovf_hit    = 1'b1;
              state_next = S_ERR;
            end
          end else begin
            if (oDataCount < (DAW+1)'(DMEM_DEPTH)) wr_data = 1'b1;
            else begin
              ovf_hit    = 1'b1;
              state_next = S_ERR;
            end
          end
        end
      end
      S_DELAY: begin
        if (dly_cnt == DLY_W'(START_DELAY - 1)) state_next = S_RUN;
      end
      S_RUN: begin
        if (iReload) state_next = S_IDLE;
      end
      S_ERR: begin
        if (iReload) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Settle-delay counter, restarts each time DELAY is entered
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                  dly_cnt <= '0;
    else if (state != S_DELAY) dly_cnt <= '0;
    else                       dly_cnt <= dly_cnt + DLY_W'(1);
  end

  // Status outputs registered from the next state
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oReady <= 1'b0;
      oBusy  <= 1'b0;
      oStart <= 1'b0;
    end else begin
      oReady <= (state_next == S_LOAD);
      oBusy  <= (state_next == S_LOAD) || (state_next == S_DELAY);
      oStart <= (state_next == S_RUN);
    end
  end

  // Memory write ports, session counts and sticky overflow
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oInstWen    <= 1'b0;
      oInstAddr   <= '0;
      oInst2Write <= '0;
      oDataWen    <= 1'b0;
      oDataAddr   <= '0;
      oData2Write <= '0;
      oInstCount  <= '0;
      oDataCount  <= '0;
      oOverflow   <= 1'b0;
    end else begin
      oInstWen <= wr_inst;
      oDataWen <= wr_data;
      if (wr_inst) begin
        oInstAddr   <= oInstCount[IAW-1:0];
        oInst2Write <= iWord;
        oInstCount  <= oInstCount + (IAW+1)'(1);
      end
      if (wr_data) begin
        oDataAddr   <= oDataCount[DAW-1:0];
        oData2Write <= iWord;
        oDataCount  <= oDataCount + (DAW+1)'(1);
      end
      if (session_start) begin
        oInstCount <= '0;
        oDataCount <= '0;
        oOverflow  <= 1'b0;
      end
      if (ovf_hit) oOverflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (IMEM_DEPTH=4, DMEM_DEPTH=8, START_DELAY=2).
module tb_prog_loader;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ID   = 4;
  localparam int unsigned DD   = 8;
  localparam logic [31:0] MARK = 32'hDEADBEAF;

  logic        clk = 1'b0;
  logic        rst, load_req, reload, target, valid;
  logic [31:0] word;
  logic        ready, inst_wen, data_wen, start, busy, ovf;
  logic [1:0]  inst_addr;
  logic [2:0]  data_addr;
  logic [31:0] inst_wdata, data_wdata;
  logic [2:0]  inst_cnt;
  logic [3:0]  data_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_loader #(
    .XLEN(XLEN), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD),
    .END_MARKER(MARK), .START_DELAY(2)
  ) dut (
    .iClk(clk), .iRst(rst), .iLoadReq(load_req), .iReload(reload),
    .iWord(word), .iTarget(target), .iValid(valid), .oReady(ready),
    .oInstAddr(inst_addr), .oInst2Write(inst_wdata), .oInstWen(inst_wen),
    .oDataAddr(data_addr), .oData2Write(data_wdata), .oDataWen(data_wen),
    .oStart(start), .oBusy(busy), .oOverflow(ovf),
    .oInstCount(inst_cnt), .oDataCount(data_cnt)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling/driving happens 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic t);
    word = w; target = t; valid = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; reload = 1'b0;
    word = '0; target = 1'b0; valid = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_wen",   64'({inst_wen, data_wen}), 64'd0);
    chk("rst_cnt",   64'({inst_cnt, data_cnt}), 64'd0);
    chk("rst_ovf",   64'(ovf), 64'd0);
    rst = 1'b0;
    tick();

    // 1: three instruction words then marker
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("t1_ready", 64'(ready), 64'd1);
    chk("t1_busy",  64'(busy),  64'd1);
    send(32'h00000013, 1'b0);
    chk("t1_w0", 64'({inst_wen, inst_addr, inst_wdata}), {29'd0, 1'b1, 2'd0, 32'h00000013});
    chk("t1_c0", 64'(inst_cnt), 64'd1);
    send(32'h00100093, 1'b0);
    chk("t1_w1", 64'({inst_wen, inst_addr, inst_wdata}), {29'd0, 1'b1, 2'd1, 32'h00100093});
    send(32'h00208113, 1'b0);
    chk("t1_w2", 64'({inst_wen, inst_addr, inst_wdata}), {29'd0, 1'b1, 2'd2, 32'h00208113});
    chk("t1_c2", 64'(inst_cnt), 64'd3);
    send(MARK, 1'b0);
    valid = 1'b0;
    chk("t1_mk_wen",   64'(inst_wen), 64'd0);
    chk("t1_mk_ready", 64'(ready), 64'd0);
    chk("t1_mk_start", 64'(start), 64'd0);
    chk("t1_mk_cnt",   64'(inst_cnt), 64'd3);
    tick();
    chk("t1_d2_start", 64'(start), 64'd0);
    chk("t1_d2_busy",  64'(busy),  64'd1);
    tick();
    chk("t1_run_start", 64'(start), 64'd1);
    chk("t1_run_busy",  64'(busy),  64'd0);

    // iLoadReq during RUN is ignored
    load_req = 1'b1; tick(); tick(); load_req = 1'b0;
    chk("t6_start", 64'(start), 64'd1);
    chk("t6_cnt",   64'(inst_cnt), 64'd3);
    chk("t6_ready", 64'(ready), 64'd0);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("t1_rel_start", 64'(start), 64'd0);

    // 2: interleaved targets with valid toggled every other cycle
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("t2_clr", 64'({inst_cnt, data_cnt}), 64'd0);
    send(32'hA0A00001, 1'b0);
    chk("t2_A", 64'({inst_wen, data_wen, inst_addr, inst_wdata}), {28'd0, 2'b10, 2'd0, 32'hA0A00001});
    valid = 1'b0; tick();
    chk("t2_gap0", 64'({inst_wen, data_wen}), 64'd0);
    send(32'hB0B00002, 1'b1);
    chk("t2_B", 64'({inst_wen, data_wen, data_addr, data_wdata}), {27'd0, 2'b01, 3'd0, 32'hB0B00002});
    valid = 1'b0; tick();
    chk("t2_gap1", 64'({inst_wen, data_wen}), 64'd0);
    send(32'hC0C00003, 1'b1);
    chk("t2_C", 64'({inst_wen, data_wen, data_addr, data_wdata}), {27'd0, 2'b01, 3'd1, 32'hC0C00003});
    valid = 1'b0; tick();
    send(32'hD0D00004, 1'b0);
    chk("t2_D", 64'({inst_wen, data_wen, inst_addr, inst_wdata}), {28'd0, 2'b10, 2'd1, 32'hD0D00004});
    chk("t2_hold_data", 64'({data_addr, data_wdata}), {29'd0, 3'd1, 32'hC0C00003});
    valid = 1'b0; tick();
    send(MARK, 1'b1);
    valid = 1'b0;
    chk("t2_cnt", 64'({inst_cnt, data_cnt}), {57'd0, 3'd2, 4'd2});
    tick(); tick();
    chk("t2_start", 64'(start), 64'd1);
    reload = 1'b1; tick(); reload = 1'b0;

    // 3: instruction overflow at depth 4
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + 32'(i), 1'b0);
      chk("t3_w", 64'({inst_wen, inst_addr, inst_wdata}), {29'd0, 1'b1, 2'(i), 32'h100 + 32'(i)});
    end
    chk("t3_full", 64'(inst_cnt), 64'd4);
    send(32'h104, 1'b0);
    valid = 1'b0;
    chk("t3_drop_wen", 64'(inst_wen), 64'd0);
    chk("t3_ovf",      64'(ovf), 64'd1);
    chk("t3_ready",    64'(ready), 64'd0);
    chk("t3_busy",     64'(busy), 64'd0);
    chk("t3_cnt",      64'(inst_cnt), 64'd4);
    chk("t3_hold",     64'(inst_wdata), 64'h103);
    tick(); tick(); tick();
    chk("t3_nostart", 64'(start), 64'd0);
    chk("t3_ovf_held", 64'(ovf), 64'd1);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("t3_idle_ovf", 64'(ovf), 64'd1);
    chk("t3_idle_ready", 64'(ready), 64'd0);
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("t3_clr_ovf", 64'(ovf), 64'd0);
    chk("t3_clr_cnt", 64'({inst_cnt, data_cnt}), 64'd0);
    chk("t3_ready2",  64'(ready), 64'd1);

    // 4: marker as first word of a session
    send(MARK, 1'b0);
    valid = 1'b0;
    chk("t4_wen", 64'({inst_wen, data_wen}), 64'd0);
    chk("t4_cnt", 64'({inst_cnt, data_cnt}), 64'd0);
    tick();
    chk("t4_wait", 64'(start), 64'd0);
    tick();
    chk("t4_start", 64'(start), 64'd1);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("t4_rel", 64'(start), 64'd0);

    // 5: reset in the middle of a stream
    load_req = 1'b1; tick(); load_req = 1'b0;
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    chk("t5_pre", 64'({inst_wen, inst_cnt}), {60'd0, 1'b1, 3'd2});
    word = 32'h33333333;
    #1 rst = 1'b1;
    #1;
    chk("t5_async_wen",   64'({inst_wen, data_wen}), 64'd0);
    chk("t5_async_cnt",   64'(inst_cnt), 64'd0);
    chk("t5_async_ready", 64'(ready), 64'd0);
    chk("t5_async_addr",  64'({inst_addr, inst_wdata}), 64'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t5_ignored_wen",   64'(inst_wen), 64'd0);
    chk("t5_ignored_ready", 64'(ready), 64'd0);
    chk("t5_ignored_cnt",   64'(inst_cnt), 64'd0);
    valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
